// File: rtl/uart_work_pkg.sv
// uart_work_pkg: shared constants and state type for the UART work-packet path.
package uart_work_pkg;
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;
    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam int PAYLOAD_BYTES_DEF = 44;
    localparam int CLKS_PER_BIT = 87;
    // ten 10-bit byte times of silence ends a frame
    localparam int TIMEOUT_CLKS_DEF = CLKS_PER_BIT * 10 * 10;
endpackage

// File: rtl/uart_byte_timer.sv
// uart_byte_timer: saturating inter-byte counter; expire flags LIMIT-1 idle clocks while enabled.
module uart_byte_timer #(
    parameter int LIMIT = uart_work_pkg::TIMEOUT_CLKS_DEF
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic expire
);
    localparam int W = $clog2(LIMIT);
    logic [W-1:0] count;
    assign expire = en && (count == W'(LIMIT - 1));
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && count != W'(LIMIT - 1))
            count <= count + 1'b1;
endmodule

// File: rtl/uart_work_assembler.sv
// uart_work_assembler: frames uart_rx bytes into checksum-verified work words for the hashing core.
module uart_work_assembler #(
    parameter int PAYLOAD_BYTES = uart_work_pkg::PAYLOAD_BYTES_DEF,
    parameter int TIMEOUT_CLKS = uart_work_pkg::TIMEOUT_CLKS_DEF,
    parameter logic [7:0] SYNC_BYTE = uart_work_pkg::SYNC_BYTE
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic                       i_Rx_DV,
    input  logic [7:0]                 i_Rx_Byte,
    input  logic                       i_Work_Ready,
    output logic                       o_Work_Valid,
    output logic [PAYLOAD_BYTES*8-1:0] o_Work_Data,
    output logic                       o_Frame_Err,
    output logic                       o_Overrun,
    output logic                       o_Busy
);
    import uart_work_pkg::*;
    localparam int IW = $clog2(PAYLOAD_BYTES + 1);
    localparam int W = PAYLOAD_BYTES * 8;
    state_t state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [7:0] csum, csum_nx;
    logic [W-1:0] shadow, shadow_nx, data_nx;
    logic valid_nx, err_nx, ovr_nx, in_frame, expire;
    assign in_frame = (state == PAYLOAD) || (state == CHECK);
    assign o_Busy = state != IDLE;
    // held clear while idle; frozen (neither counting nor clearing) in HOLD
    uart_byte_timer #(.LIMIT(TIMEOUT_CLKS)) u_timer (
        .clock (i_Clock),
        .rst_n (i_Rst_n),
        .en    (in_frame),
        .clear ((state == IDLE) || (in_frame && i_Rx_DV)),
        .expire(expire)
    );
    always_comb begin
        state_nx = state;
        idx_nx = idx;
        csum_nx = csum;
        shadow_nx = shadow;
        data_nx = o_Work_Data;
        valid_nx = o_Work_Valid;
        err_nx = 1'b0;
        ovr_nx = 1'b0;
        case (state)
            IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
                state_nx = PAYLOAD;
                idx_nx = '0;
                csum_nx = '0;
            end
            PAYLOAD: if (i_Rx_DV) begin
                for (int i = 0; i < PAYLOAD_BYTES; i++)
                    if (idx == IW'(i)) shadow_nx[(PAYLOAD_BYTES-1-i)*8 +: 8] = i_Rx_Byte;
                csum_nx = csum ^ i_Rx_Byte;
                idx_nx = idx + 1'b1;
                state_nx = (idx == IW'(PAYLOAD_BYTES - 1)) ? CHECK : PAYLOAD;
            end else if (expire) begin
                err_nx = 1'b1;
                state_nx = IDLE;
            end
            CHECK: if (i_Rx_DV) begin
                if (i_Rx_Byte == csum) begin
                    data_nx = shadow;
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end else begin
                    err_nx = 1'b1;
                    state_nx = IDLE;
                end
            end else if (expire) begin
                err_nx = 1'b1;
                state_nx = IDLE;
            end
            HOLD: begin
                ovr_nx = i_Rx_DV;
                if (i_Work_Ready) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_Clock or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state <= IDLE;
            idx <= '0;
            csum <= '0;
            shadow <= '0;
            o_Work_Data <= '0;
            o_Work_Valid <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            state <= state_nx;
            idx <= idx_nx;
            csum <= csum_nx;
            shadow <= shadow_nx;
            o_Work_Data <= data_nx;
            o_Work_Valid <= valid_nx;
            o_Frame_Err <= err_nx;
            o_Overrun <= ovr_nx;
        end
endmodule

// File: tb/tb_uart_work_assembler.sv
`timescale 1ns/1ps
// tb_uart_work_assembler: directed and randomized frames checked against a byte-level frame model.
module tb_uart_work_assembler;
    localparam int PB = 4;
    localparam int TO = 8700;
    logic clk = 1'b0, rst_n = 1'b0, dv = 1'b0, ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic valid, err, ovr, busy;
    logic [PB*8-1:0] data;
    int passes = 0, checks = 0, fails = 0, err_cnt = 0, ovr_cnt = 0;

    uart_work_assembler #(.PAYLOAD_BYTES(PB), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (dv),
        .i_Rx_Byte   (rx_byte),
        .i_Work_Ready(ready),
        .o_Work_Valid(valid),
        .o_Work_Data (data),
        .o_Frame_Err (err),
        .o_Overrun   (ovr),
        .o_Busy      (busy)
    );

    always #50 clk = ~clk;

    // pulse counters sample the pre-edge value, so a pulse is counted one edge after it rises
    always @(posedge clk) begin
        if (err) err_cnt++;
        if (ovr) ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        dv = 1'b1;
        rx_byte = b;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] p [PB], input int gap);
        send_byte(8'hAA, gap);
        for (int i = 0; i < PB; i++) send_byte(p[i], gap);
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] p [PB]);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < PB; i++) x = x ^ p[i];
        return x;
    endfunction

    function automatic logic [31:0] word_of(input logic [7:0] p [PB]);
        logic [31:0] w = '0;
        for (int i = 0; i < PB; i++) w = (w << 8) | 32'(p[i]);
        return w;
    endfunction

    task automatic accept(input string tag, input int delay);
        repeat (delay) @(negedge clk);
        check({tag, "_valid_held"}, 32'(valid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] p [PB];
        logic [31:0] exp_data;
        int e0, o0, gap;
        bit bad;
        #20;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: good frame, held without ready, then handshake
        p = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_payload(p, 1);
        check("t1_valid_before_chk", 32'(valid), 32'd0);
        send_byte(xor_of(p), 1);
        check("t1_valid_latency", 32'(valid), 32'd1);
        check("t1_data", data, 32'h01020304);
        repeat (100) @(negedge clk);
        check("t1_data_stable", data, 32'h01020304);
        accept("t1", 0);
        exp_data = 32'h01020304;

        // 2: checksum mismatch, then a good frame
        e0 = err_cnt;
        send_payload(p, 1);
        send_byte(8'h05, 1);
        check("t2_err_pulse", 32'(err), 32'd1);
        @(negedge clk);
        check("t2_err_one_cycle", 32'(err), 32'd0);
        @(negedge clk);
        check("t2_err_count", 32'(err_cnt - e0), 32'd1);
        check("t2_no_valid", 32'(valid), 32'd0);
        check("t2_data_kept", data, exp_data);
        p = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_payload(p, 2);
        send_byte(8'h40, 2);
        check("t2_good_data", data, word_of(p));
        accept("t2", 3);
        exp_data = word_of(p);

        // 3: timeout after AA 01 02, then a byte landing on the expiry cycle
        e0 = err_cnt;
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        repeat (TO - 1) @(negedge clk);
        check("t3_no_early_err", 32'(err_cnt - e0), 32'd0);
        check("t3_busy_before", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_timeout_err", 32'(err_cnt - e0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        e0 = err_cnt;
        send_byte(8'hAA, 1);
        send_byte(8'h05, 1);
        send_byte(8'h06, 1);
        send_byte(8'h07, TO - 1);
        send_byte(8'h08, 1);
        send_byte(8'h0C, 1);
        @(negedge clk);
        check("t3_expiry_byte_err", 32'(err_cnt - e0), 32'd0);
        check("t3_expiry_byte_data", data, 32'h05060708);
        accept("t3", 1);

        // 4: leading garbage, and sync values inside the payload
        e0 = err_cnt;
        send_byte(8'h55, 1);
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_payload(p, 1);
        send_byte(8'h22, 1);
        check("t4_garbage_data", data, 32'hDEADBEEF);
        accept("t4a", 2);
        p = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
        send_payload(p, 0);
        send_byte(8'h00, 0);
        check("t4_sync_payload", data, 32'hAAAAAAAA);
        check("t4_no_err", 32'(err_cnt - e0), 32'd0);
        accept("t4b", 0);

        // 5: overrun while holding, including a sync byte in the handover cycle
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_payload(p, 1);
        send_byte(xor_of(p), 1);
        o0 = ovr_cnt;
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        repeat (2) @(negedge clk);
        check("t5_overrun3", 32'(ovr_cnt - o0), 32'd3);
        check("t5_data_kept", data, 32'h11223344);
        check("t5_valid_kept", 32'(valid), 32'd1);
        ready = 1'b1;
        dv = 1'b1;
        rx_byte = 8'hAA;
        @(negedge clk);
        ready = 1'b0;
        dv = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_handover_ovr", 32'(ovr_cnt - o0), 32'd4);
        check("t5_handover_idle", 32'(busy), 32'd0);
        check("t5_handover_valid", 32'(valid), 32'd0);

        // 6: asynchronous reset mid-frame
        send_byte(8'hAA, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        #13 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_data", data, 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        p = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        send_payload(p, 1);
        send_byte(8'h00, 1);
        check("t6_after_rst", data, 32'h0A0B0C0D);
        accept("t6", 1);
        exp_data = 32'h0A0B0C0D;

        // randomized frames: garbage, random gaps, occasional corrupted checksum
        for (int n = 0; n < 12; n++) begin
            e0 = err_cnt;
            gap = $urandom_range(0, 3);
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                logic [7:0] junk = 8'($urandom_range(0, 255));
                send_byte(junk == 8'hAA ? 8'h55 : junk, gap);
            end
            for (int i = 0; i < PB; i++) p[i] = 8'($urandom_range(0, 255));
            bad = $urandom_range(0, 2) == 0;
            send_payload(p, gap);
            send_byte(xor_of(p) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00), gap);
            if (!bad) exp_data = word_of(p);
            repeat (2) @(negedge clk);
            check($sformatf("rnd%0d_err", n), 32'(err_cnt - e0), bad ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d_valid", n), 32'(valid), bad ? 32'd0 : 32'd1);
            check($sformatf("rnd%0d_data", n), data, exp_data);
            if (!bad) accept($sformatf("rnd%0d", n), $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_work_assembler.md
Name: uart_work_assembler

Overview:
- Sits directly downstream of uart_rx. Consumes its o_Rx_DV / o_Rx_Byte strobe stream.
- Assembles framed host-to-FPGA work packets (midstate plus header tail) into one wide, checksum-verified word.
- Presents that word to the hashing core with a valid/ready handshake.
- Operates in the 10 MHz UART clock domain, at 87 clocks per bit (115200 baud).

Parameters:
- PAYLOAD_BYTES, 44: payload bytes per frame (32 midstate + 12 header tail).
- SYNC_BYTE, 8'hAA: frame start marker.
- TIMEOUT_CLKS, 8700: maximum clocks between consecutive bytes inside a frame (10 byte times at 87 clocks/bit).

Ports:
- i_Clock  in  1  system clock, 10 MHz, rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Rx_DV  in  1  one-cycle strobe from uart_rx: i_Rx_Byte valid this cycle.
- i_Rx_Byte  in  8  received byte.
- i_Work_Ready  in  1  hashing core can accept work.
- o_Work_Valid  out  1  o_Work_Data holds a verified packet.
- o_Work_Data  out  PAYLOAD_BYTES*8  assembled payload; first byte received at the MSBs.
- o_Frame_Err  out  1  one-cycle pulse on checksum mismatch or timeout.
- o_Overrun  out  1  one-cycle pulse when a byte is dropped in HOLD.
- o_Busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_Clock. i_Rst_n is asynchronous and active-low, asserting immediately and released synchronously by the upstream reset bridge.
- Reset values:
  - all outputs 0; o_Work_Data 0;
  - state IDLE; byte index 0; running checksum 0; timeout counter 0.
- Frame format: SYNC_BYTE, then PAYLOAD_BYTES payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes.
- State IDLE:
  - i_Rx_DV with byte == SYNC_BYTE -> PAYLOAD; clear index, checksum and timer.
  - any other byte is silently discarded; no error pulse.
- State PAYLOAD:
  - each i_Rx_DV writes the byte to lane [(PAYLOAD_BYTES-1-idx)*8 +: 8] of the shadow register.
  - checksum ^= byte; idx++; timer cleared.
  - when idx reaches PAYLOAD_BYTES-1 and that byte is accepted -> CHECK.
  - SYNC_BYTE values inside the payload are ordinary data.
- State CHECK:
  - on i_Rx_DV, if byte == checksum: copy shadow to o_Work_Data, set o_Work_Valid, go to HOLD.
  - otherwise pulse o_Frame_Err and go to IDLE; o_Work_Data is unchanged.
- Latency: checksum-byte strobe at cycle t -> o_Work_Valid = 1 at t+1.
- Timeout (PAYLOAD and CHECK only):
  - the timer increments on every cycle without i_Rx_DV.
  - reaching TIMEOUT_CLKS-1 -> pulse o_Frame_Err and go to IDLE.
  - if i_Rx_DV arrives in the same cycle the timer expires, the byte wins: it is accepted and the timer clears.
- State HOLD:
  - o_Work_Valid stays high and o_Work_Data stays stable until i_Work_Ready is sampled high.
  - that cycle: o_Work_Valid -> 0 at the next edge; go to IDLE.
  - i_Rx_DV during HOLD drops the byte and pulses o_Overrun, including a SYNC_BYTE in the handover cycle.
  - the timer is frozen in HOLD.
- Handshake: o_Work_Valid is never deasserted without acceptance. A transfer is i_Work_Ready & o_Work_Valid on the same edge.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is discarded, and the next frame must start with SYNC_BYTE.
- Widths:
  - index: $clog2(PAYLOAD_BYTES+1) bits.
  - timer: $clog2(TIMEOUT_CLKS) bits, saturating; no wrap.

Decomposition:
- Shared package uart_work_pkg holds:
  - state enum {IDLE, PAYLOAD, CHECK, HOLD};
  - SYNC_BYTE and the default PAYLOAD_BYTES constants;
  - the clocks-per-bit constant 87, shared with uart_rx and uart_tx;
  - TIMEOUT_CLKS derived from that constant.
- One sub-module, uart_byte_timer: a saturating inter-byte counter with clear and expire outputs. It is reusable by the future nonce-report path.

Test Plan (PAYLOAD_BYTES=4, TIMEOUT_CLKS=8700):
1. Frame AA 01 02 03 04 04, with i_Work_Ready held 0 -> o_Work_Valid rises one cycle after the last strobe, with o_Work_Data=32'h01020304. It stays stable 100 cycles. Assert ready -> valid drops next cycle, o_Busy=0.
2. Frame AA 01 02 03 04 05 -> o_Frame_Err pulses exactly once, o_Work_Valid stays 0, o_Work_Data unchanged. A following good frame AA 10 20 30 40 40 is accepted.
3. AA 01 02, then idle 8700 clocks -> o_Frame_Err pulses once, state IDLE. A byte strobed on exactly the expiry cycle instead is accepted with no error.
4. Leading garbage 55 00 FF, then AA DE AD BE EF 22 -> no error; o_Work_Data=32'hDEADBEEF. Payload containing AA (AA AA AA AA AA 00) is accepted as 32'hAAAAAAAA.
5. Valid frame held in HOLD, then 3 more bytes strobed -> o_Overrun pulses 3 times and o_Work_Data is unchanged.
6. Assert i_Rst_n low asynchronously after AA 01 02 -> outputs 0 immediately. After release, frame AA 0A 0B 0C 0D 00 yields 32'h0A0B0C0D.
